// File: rtl/cram_arbiter.sv
// Cart RAM arbiter: CPU, mapper-direct writes and 16-bit backup words
// share one synchronous single-port RAM; read data is routed by owner tag.
module cram_arbiter #(
   parameter int AW = 17
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ce_cpu,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_di,
   output logic [7:0]    cpu_do,
   input  logic          map_wr,
   input  logic [AW-1:0] map_addr,
   input  logic [7:0]    map_data,
   output logic          map_busy,
   input  logic          bk_rd,
   input  logic          bk_wr,
   input  logic [AW-2:0] bk_addr,
   input  logic [15:0]   bk_data,
   output logic [15:0]   bk_q,
   output logic          bk_ack,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_d,
   input  logic [7:0]    ram_q
);

   localparam logic [2:0] B_IDLE = 3'd0;
   localparam logic [2:0] B_LO   = 3'd1;
   localparam logic [2:0] B_HI   = 3'd2;
   localparam logic [2:0] B_WAIT = 3'd3;
   localparam logic [2:0] B_ACK  = 3'd4;

   localparam logic [1:0] T_NONE = 2'd0;
   localparam logic [1:0] T_CPU  = 2'd1;
   localparam logic [1:0] T_BLO  = 2'd2;
   localparam logic [1:0] T_BHI  = 2'd3;

   logic [2:0]    st_q, st_d;
   logic          op_q, op_d;
   logic [AW-2:0] ba_q, ba_d;
   logic [15:0]   bd_q, bd_d;
   logic          mp_q, mp_d;
   logic [AW-1:0] ma_q, ma_d;
   logic [7:0]    md_q, md_d;
   logic [1:0]    tag_q, tag_d;
   logic [7:0]    cdo_q, cdo_d;
   logic [15:0]   bkq_q, bkq_d;
   logic [AW-1:0] addr_q;
   logic [7:0]    dat_q;

   logic cpu_req, bk_step, bk_hi;
   logic gnt_cpu, gnt_map, gnt_bk;

   assign cpu_req = ce_cpu & (cpu_rd | cpu_wr);
   assign bk_step = (st_q == B_LO) | (st_q == B_HI);
   assign bk_hi   = (st_q == B_HI);
   assign gnt_cpu = ~reset & cpu_req;
   assign gnt_map = ~reset & ~cpu_req & mp_q;
   assign gnt_bk  = ~reset & ~cpu_req & ~mp_q & bk_step;

   // RAM port mux; an idle cycle keeps the last address and data
   always_comb begin
      ram_addr = addr_q;
      ram_we   = 1'b0;
      ram_d    = dat_q;
      tag_d    = T_NONE;
      if (gnt_cpu) begin
         ram_addr = cpu_addr;
         ram_we   = cpu_wr;
         ram_d    = cpu_di;
         if (!cpu_wr) tag_d = T_CPU;
      end else if (gnt_map) begin
         ram_addr = ma_q;
         ram_we   = 1'b1;
         ram_d    = md_q;
      end else if (gnt_bk) begin
         ram_addr = {ba_q, bk_hi};
         ram_we   = op_q;
         ram_d    = bk_hi ? bd_q[15:8] : bd_q[7:0];
         if (!op_q) tag_d = bk_hi ? T_BHI : T_BLO;
      end
      if (reset) begin
         ram_addr = '0;
         ram_d    = '0;
      end
   end

   // newest map_wr wins; a grant in the same cycle issues the old entry
   always_comb begin
      mp_d = (mp_q & ~gnt_map) | map_wr;
      ma_d = map_wr ? map_addr : ma_q;
      md_d = map_wr ? map_data : md_q;
   end

   always_comb begin
      st_d = st_q;
      op_d = op_q;
      ba_d = ba_q;
      bd_d = bd_q;
      unique case (st_q)
         B_IDLE: begin
            if (bk_rd | bk_wr) begin
               st_d = B_LO;
               op_d = bk_wr;
               ba_d = bk_addr;
               bd_d = bk_data;
            end
         end
         B_LO:   if (gnt_bk) st_d = B_HI;
         B_HI:   if (gnt_bk) st_d = op_q ? B_ACK : B_WAIT;
         B_WAIT: st_d = B_ACK;
         B_ACK:  st_d = B_IDLE;
         default: st_d = B_IDLE;
      endcase
   end

   always_comb begin
      cdo_d = (tag_q == T_CPU) ? ram_q : cdo_q;
      bkq_d = bkq_q;
      if (tag_q == T_BLO) bkq_d[7:0]  = ram_q;
      if (tag_q == T_BHI) bkq_d[15:8] = ram_q;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         st_q   <= B_IDLE;
         op_q   <= 1'b0;
         ba_q   <= '0;
         bd_q   <= '0;
         mp_q   <= 1'b0;
         ma_q   <= '0;
         md_q   <= '0;
         tag_q  <= T_NONE;
         cdo_q  <= 8'hFF;
         bkq_q  <= '0;
         addr_q <= '0;
         dat_q  <= '0;
      end else begin
         st_q   <= st_d;
         op_q   <= op_d;
         ba_q   <= ba_d;
         bd_q   <= bd_d;
         mp_q   <= mp_d;
         ma_q   <= ma_d;
         md_q   <= md_d;
         tag_q  <= tag_d;
         cdo_q  <= cdo_d;
         bkq_q  <= bkq_d;
         addr_q <= ram_addr;
         dat_q  <= ram_d;
      end
   end

   assign cpu_do   = (tag_q == T_CPU) ? ram_q : cdo_q;
   assign bk_q     = bkq_q;
   assign bk_ack   = (st_q == B_ACK);
   assign map_busy = mp_q;

endmodule
